mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Multicycle memory front end between the microcoded controller and external memory.
//  Turns the controller's MemRead/MemWrite/IorD/IRWrite into a readM/writeM handshake.
//  Latches fetched words into the instruction register (IR, which feeds the controller's inst input) or into the MDR.
//  Tells the controller, via mem_done, when it may advance its micro-state.
// PARAMETERS
//  WORD_SIZE  16  data/address width (`WORD_SIZE from opcodes.v)
//  TIMEOUT    15  max wait cycles for inputReady/ackOutput before error abort
// PORTS
//  clk          in   1   single system clock; all state updates on posedge
//  reset        in   1   synchronous, active-high reset
//  pc_addr      in   16  address used when iord=0 (instruction fetch)
//  alu_addr     in   16  address used when iord=1 (data access)
//  store_data   in   16  write data for stores
//  iord         in   1   address select from controller
//  mem_read     in   1   controller MemRead request
//  mem_write    in   1   controller MemWrite request
//  ir_write     in   1   controller IRWrite: route read data to IR, else MDR
//  ir_out       out  16  instruction register, to controller inst / decode
//  mdr_out      out  16  memory data register, to register-file write mux
//  mem_done     out  1   one-cycle pulse: access complete, controller may advance
//  mem_err      out  1   sticky: timeout or read+write conflict; cleared only by reset
//  readM        out  1   external read strobe
//  writeM       out  1   external write strobe
//  address      out  16  external address
//  data_out     out  16  external write data
//  data_in      in   16  external read data
//  inputReady   in   1   memory: data_in valid for read
//  ackOutput    in   1   memory: write accepted
// BEHAVIOUR
//  Reset values: every output 0, ir_out=0, mdr_out=0, state=IDLE, timeout counter=0.
//  FSM states: IDLE, RD_WAIT, WR_WAIT, DONE.
//  IDLE:
//   - mem_read & !mem_write: latch address (iord mux), latch dst=ir_write; -> RD_WAIT.
//   - mem_write & !mem_read: latch address and store_data; -> WR_WAIT.
//   - both high: set mem_err, no access, -> DONE.
//   - neither: stay in IDLE.
//  RD_WAIT: readM=1, address held.
//   - On the edge where inputReady=1: data_in -> IR if dst=1, else -> MDR; -> DONE.
//  WR_WAIT: writeM=1, address and data_out held.
//   - On the edge where ackOutput=1: -> DONE.
//  Timeout: counter clears on entering a WAIT state and increments each cycle in it.
//   - At count==TIMEOUT with no response: set mem_err, leave IR/MDR untouched, -> DONE.
//  DONE: mem_done=1 for exactly one cycle, strobes low; -> IDLE unconditionally.
//  Latency:
//   - Zero-wait memory (ready in first WAIT cycle): request@T, strobe@T+1, mem_done@T+2.
//   - Back-to-back accesses need at least 3 cycles each.
//  Requests are sampled only in IDLE. The controller holds its request until mem_done.
//   - Deasserting the request mid-WAIT does not abort; the access completes.
//   - A request still high during DONE is ignored. It is re-sampled in IDLE, so it starts a new access.
//  inputReady/ackOutput outside the matching WAIT state are ignored.
//  IR/MDR change only on a successful read completion. Both hold across writes and errors.
//  readM and writeM are never high together. Both are registered (glitch-free).
//  Reset mid-access: at the next edge, state=IDLE, strobes drop, IR/MDR are zeroed, and the in-flight access is discarded.
// STRUCTURE
//  `WORD_SIZE comes from opcodes.v.
//  A shared header mem_if_defs.v holds:
//   - state encodings MA_IDLE=2'd0, MA_RD_WAIT=2'd1, MA_WR_WAIT=2'd2, MA_DONE=2'd3;
//   - the TIMEOUT default.
//  One sub-module, mem_timeout_ctr: clear, enable, 4-bit count, expired flag.
//  The FSM, address/data latches and IR/MDR are in this module.
// TESTING
//  1 Fetch: pc_addr=0x0010, mem_read=1, ir_write=1, inputReady 1 cycle after readM, data_in=0x6A05
//    -> ir_out=0x6A05, mdr_out unchanged, mem_done pulse 1 cycle, address=0x0010 during readM.
//  2 Load with 3 wait cycles: iord=1, alu_addr=0x0042, ir_write=0, data_in=0xBEEF
//    -> readM high for 4 cycles, mdr_out=0xBEEF, ir_out unchanged.
//  3 Store: alu_addr=0x0080, store_data=0x1234, ackOutput after 2 cycles
//    -> writeM=1 with address=0x0080 and data_out=0x1234 held until ack; mem_done; IR/MDR unchanged.
//  4 Timeout: read with inputReady never asserted -> mem_done after TIMEOUT+2 cycles, mem_err=1, IR/MDR unchanged;
//    the next normal fetch still completes and mem_err stays 1.
//  5 Conflict: mem_read=mem_write=1 in IDLE -> no strobe ever, mem_done next cycle, mem_err=1.
//  6 Reset mid-read: reset=1 during RD_WAIT -> next edge readM=0, ir_out=0, mem_done=0;
//    a late inputReady is ignored.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit.
//   MaWordSize : data/address width
//   MaTimeout  : default number of wait cycles before an access is abandoned
//   MaCntW     : width of the wait-cycle counter
//   ma_state_e : FSM state encoding (IDLE=0, RD_WAIT=1, WR_WAIT=2, DONE=3)
package mem_access_unit_pkg;

    localparam int unsigned MaWordSize = 16;
    localparam int unsigned MaTimeout  = 15;
    localparam int unsigned MaCntW     = 4;

    typedef enum logic [1:0] {
        MaIdle   = 2'd0,
        MaRdWait = 2'd1,
        MaWrWait = 2'd2,
        MaDone   = 2'd3
    } ma_state_e;

    function automatic logic is_wait(input ma_state_e s);
        return (s == MaRdWait) || (s == MaWrWait);
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Wait-cycle counter for the memory access unit.
//   clk, reset : system clock, synchronous active-high reset
//   clear      : zero the count (entry into a wait state)
//   enable     : count one wait cycle
//   count      : current number of wait cycles spent
//   expired    : count has reached LIMIT; the counter holds there
module mem_timeout_ctr
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned LIMIT = MaTimeout
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              enable,
    output logic [MaCntW-1:0] count,
    output logic              expired
);

    logic [MaCntW-1:0] count_q;

    assign count   = count_q;
    assign expired = (count_q == MaCntW'(LIMIT));

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && !expired) begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Multicycle memory front end between the microcoded controller and external memory.
// Converts MemRead/MemWrite/IorD/IRWrite into a registered readM/writeM handshake,
// captures read data into IR or MDR, and pulses mem_done when the controller may advance.
//   clk, reset             : system clock, synchronous active-high reset
//   pc_addr, alu_addr      : fetch / data address, selected by iord
//   store_data             : write data for stores
//   iord, mem_read,
//   mem_write, ir_write    : controller request controls
//   ir_out, mdr_out        : instruction register / memory data register
//   mem_done               : one-cycle completion pulse
//   mem_err                : sticky timeout or read+write conflict flag
//   readM, writeM, address,
//   data_out               : external memory request side
//   data_in, inputReady,
//   ackOutput              : external memory response side
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned WORD_SIZE = MaWordSize,
    parameter int unsigned TIMEOUT   = MaTimeout
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WORD_SIZE-1:0] pc_addr,
    input  logic [WORD_SIZE-1:0] alu_addr,
    input  logic [WORD_SIZE-1:0] store_data,
    input  logic                 iord,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic                 ir_write,
    output logic [WORD_SIZE-1:0] ir_out,
    output logic [WORD_SIZE-1:0] mdr_out,
    output logic                 mem_done,
    output logic                 mem_err,
    output logic                 readM,
    output logic                 writeM,
    output logic [WORD_SIZE-1:0] address,
    output logic [WORD_SIZE-1:0] data_out,
    input  logic [WORD_SIZE-1:0] data_in,
    input  logic                 inputReady,
    input  logic                 ackOutput
);

    ma_state_e state_q, state_d;

    logic [WORD_SIZE-1:0] addr_q, wdata_q, ir_q, mdr_q;
    logic                 dst_ir_q, err_q, readm_q, writem_q, done_q;

    logic readm_d, writem_d, done_d;
    logic latch_req, rd_ok, err_set;

    logic              tmo_clear, tmo_enable, tmo_expired;
    logic [MaCntW-1:0] tmo_count;

    assign ir_out   = ir_q;
    assign mdr_out  = mdr_q;
    assign mem_done = done_q;
    assign mem_err  = err_q;
    assign readM    = readm_q;
    assign writeM   = writem_q;
    assign address  = addr_q;
    assign data_out = wdata_q;

    // Counter restarts on every entry into a wait state and runs while waiting.
    assign tmo_clear  = (state_q == MaIdle) && is_wait(state_d);
    assign tmo_enable = is_wait(state_q);

    mem_timeout_ctr #(
        .LIMIT (TIMEOUT)
    ) u_timeout_ctr (
        .clk     (clk),
        .reset   (reset),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .count   (tmo_count),
        .expired (tmo_expired)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MaIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a response in the final wait cycle still counts as success.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            MaIdle: begin
                if (mem_read && mem_write) begin
                    state_d = MaDone;
                end else if (mem_read) begin
                    state_d = MaRdWait;
                end else if (mem_write) begin
                    state_d = MaWrWait;
                end
            end
            MaRdWait: if (inputReady || tmo_expired) state_d = MaDone;
            MaWrWait: if (ackOutput || tmo_expired) state_d = MaDone;
            MaDone:   state_d = MaIdle;
            default:  state_d = MaIdle;
        endcase
    end

    // Output logic: strobes and done are registered from the next state so they
    // line up with the state they belong to without decode glitches.
    always_comb begin
        readm_d   = (state_d == MaRdWait);
        writem_d  = (state_d == MaWrWait);
        done_d    = (state_d == MaDone);
        latch_req = (state_q == MaIdle) && (mem_read != mem_write);
        rd_ok     = (state_q == MaRdWait) && inputReady;
        err_set   = ((state_q == MaIdle) && mem_read && mem_write)
                  || ((state_q == MaRdWait) && !inputReady && tmo_expired)
                  || ((state_q == MaWrWait) && !ackOutput && tmo_expired);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            dst_ir_q <= 1'b0;
            ir_q     <= '0;
            mdr_q    <= '0;
            err_q    <= 1'b0;
            readm_q  <= 1'b0;
            writem_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            readm_q  <= readm_d;
            writem_q <= writem_d;
            done_q   <= done_d;
            if (latch_req) begin
                addr_q   <= iord ? alu_addr : pc_addr;
                dst_ir_q <= ir_write;
                if (mem_write) begin
                    wdata_q <= store_data;
                end
            end
            if (rd_ok) begin
                if (dst_ir_q) begin
                    ir_q <= data_in;
                end else begin
                    mdr_q <= data_in;
                end
            end
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    // The counter saturates at the limit; a larger value means it escaped its bound.
    a_count_bounded : assert property (@(posedge clk) disable iff (reset)
        tmo_count <= MaCntW'(TIMEOUT));

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    localparam int TMO = 15;

    logic        clk, reset;
    logic [15:0] pc_addr, alu_addr, store_data;
    logic        iord, mem_read, mem_write, ir_write;
    logic [15:0] ir_out, mdr_out;
    logic        mem_done, mem_err, readM, writeM;
    logic [15:0] address, data_out, data_in;
    logic        inputReady, ackOutput;

    mem_access_unit #(
        .WORD_SIZE (16),
        .TIMEOUT   (TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pc_addr    (pc_addr),
        .alu_addr   (alu_addr),
        .store_data (store_data),
        .iord       (iord),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .ir_out     (ir_out),
        .mdr_out    (mdr_out),
        .mem_done   (mem_done),
        .mem_err    (mem_err),
        .readM      (readM),
        .writeM     (writeM),
        .address    (address),
        .data_out   (data_out),
        .data_in    (data_in),
        .inputReady (inputReady),
        .ackOutput  (ackOutput)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // kind: 0 = read, 1 = write, 2 = read+write conflict
    typedef struct {
        logic [15:0] ir;
        logic [15:0] mdr;
        logic        err;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          kind;
        int          strobes;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;

    // Reference state of the architecturally visible registers
    logic [15:0] m_ir = 16'h0;
    logic [15:0] m_mdr = 16'h0;
    logic        m_err = 1'b0;

    int          cur_lat = 0;
    logic [15:0] cur_rdata = 16'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory model: responds after cur_lat strobe cycles; outside the matching
    // strobe it throws in stray handshakes that the unit must ignore.
    initial begin
        int n;
        n = 0;
        inputReady = 1'b0;
        ackOutput  = 1'b0;
        data_in    = 16'h0;
        forever begin
            @(negedge clk);
            if (readM) begin
                inputReady = (n == cur_lat);
                ackOutput  = 1'($urandom_range(0, 1));
                data_in    = (n == cur_lat) ? cur_rdata : 16'($urandom);
                n++;
            end else if (writeM) begin
                ackOutput  = (n == cur_lat);
                inputReady = 1'($urandom_range(0, 1));
                data_in    = 16'($urandom);
                n++;
            end else begin
                n = 0;
                inputReady = ($urandom_range(0, 3) == 0);
                ackOutput  = ($urandom_range(0, 3) == 0);
                data_in    = 16'($urandom);
            end
        end
    end

    // Monitor: checks strobe-phase outputs against the pending entry and pops on mem_done.
    initial begin
        int   strobes;
        logic prev_done;
        exp_t e;
        strobes   = 0;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                strobes   = 0;
                prev_done = 1'b0;
            end else begin
                if (readM || writeM) begin
                    strobes++;
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL strobe_unexpected: got readM=%b writeM=%b expected none",
                                 readM, writeM);
                    end else begin
                        e = sb[0];
                        check("strobe_kind", {30'h0, readM, writeM},
                              (e.kind == 0) ? 32'h2 : 32'h1);
                        check("address", {16'h0, address}, {16'h0, e.addr});
                        if (writeM) check("data_out", {16'h0, data_out}, {16'h0, e.wdata});
                    end
                end
                if (mem_done) begin
                    check("done_single_cycle", {31'h0, prev_done}, 32'h0);
                    check("done_strobes_low", {30'h0, readM, writeM}, 32'h0);
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL done_unexpected: got mem_done=1 expected 0");
                    end else begin
                        e = sb.pop_front();
                        check("ir_out", {16'h0, ir_out}, {16'h0, e.ir});
                        check("mdr_out", {16'h0, mdr_out}, {16'h0, e.mdr});
                        check("mem_err", {31'h0, mem_err}, {31'h0, e.err});
                        check("strobe_cycles", strobes, e.strobes);
                    end
                    strobes = 0;
                end
                prev_done = mem_done;
            end
        end
    end

    task automatic do_txn(input int kind, input logic t_iord, input logic t_irw,
                          input logic [15:0] pc, input logic [15:0] alu,
                          input logic [15:0] sd, input logic [15:0] rdata, input int lat);
        exp_t e;
        int   done_lat;
        int   k;
        bit   drop_early;
        bit   ok;
        ok = (lat <= TMO);
        if (kind == 2) begin
            m_err     = 1'b1;
            e.strobes = 0;
            done_lat  = 1;
        end else begin
            e.strobes = ok ? lat + 1 : TMO + 1;
            done_lat  = ok ? lat + 2 : TMO + 2;
            if (!ok) m_err = 1'b1;
            else if (kind == 0) begin
                if (t_irw) m_ir = rdata;
                else m_mdr = rdata;
            end
        end
        e.kind  = kind;
        e.addr  = t_iord ? alu : pc;
        e.wdata = sd;
        e.ir    = m_ir;
        e.mdr   = m_mdr;
        e.err   = m_err;
        sb.push_back(e);
        cur_lat    = lat;
        cur_rdata  = rdata;
        drop_early = ($urandom_range(0, 3) == 0);

        @(negedge clk);
        pc_addr    = pc;
        alu_addr   = alu;
        store_data = sd;
        iord       = t_iord;
        ir_write   = t_irw;
        mem_read   = (kind != 1);
        mem_write  = (kind != 0);
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (!mem_done) begin
                // Inputs are latched; scrambling them must not disturb the access.
                pc_addr    = 16'($urandom);
                alu_addr   = 16'($urandom);
                store_data = 16'($urandom);
                iord       = 1'($urandom);
                ir_write   = 1'($urandom);
                if (drop_early) begin
                    mem_read  = 1'b0;
                    mem_write = 1'b0;
                end
            end
        end while (!mem_done && k < 40);
        if (!mem_done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no mem_done after %0d cycles expected %0d",
                     k, done_lat);
        end else begin
            check("done_latency", k, done_lat);
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int kind;
        int lat;
        reset      = 1'b1;
        pc_addr    = 16'h0;
        alu_addr   = 16'h0;
        store_data = 16'h0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ir", {16'h0, ir_out}, 32'h0);
        check("rst_mdr", {16'h0, mdr_out}, 32'h0);
        check("rst_done", {31'h0, mem_done}, 32'h0);
        check("rst_err", {31'h0, mem_err}, 32'h0);
        check("rst_strobes", {30'h0, readM, writeM}, 32'h0);
        check("rst_address", {16'h0, address}, 32'h0);
        check("rst_data_out", {16'h0, data_out}, 32'h0);
        reset = 1'b0;

        // Directed cases
        do_txn(0, 1'b0, 1'b1, 16'h0010, 16'h5555, 16'h0, 16'h6A05, 1);   // fetch
        do_txn(0, 1'b1, 1'b0, 16'h3333, 16'h0042, 16'h0, 16'hBEEF, 3);   // load, 3 waits
        do_txn(1, 1'b1, 1'b0, 16'h3333, 16'h0080, 16'h1234, 16'h0, 2);   // store
        do_txn(0, 1'b1, 1'b1, 16'h0, 16'h00A0, 16'h0, 16'h7777, TMO);    // last-chance read
        do_txn(0, 1'b0, 1'b1, 16'h0020, 16'h0, 16'h0, 16'hDEAD, 100);    // timeout
        do_txn(0, 1'b0, 1'b1, 16'h0024, 16'h0, 16'h0, 16'h1357, 0);      // fetch after error
        do_txn(2, 1'b0, 1'b0, 16'h0030, 16'h0, 16'h0, 16'h0, 0);         // conflict
        do_txn(1, 1'b0, 1'b0, 16'h0040, 16'h0, 16'hCAFE, 16'h0, 100);    // write timeout

        // Randomized traffic
        for (int i = 0; i < 80; i++) begin
            kind = ($urandom_range(0, 19) == 0) ? 2 : int'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0:       lat = TMO;
                1:       lat = TMO + 1 + int'($urandom_range(0, 5));
                default: lat = int'($urandom_range(0, 5));
            endcase
            do_txn(kind, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
                   16'($urandom), 16'($urandom), lat);
        end

        // Reset in the middle of a read
        begin
            exp_t e;
            e.kind    = 0;
            e.addr    = 16'h0100;
            e.wdata   = 16'h0;
            e.ir      = m_ir;
            e.mdr     = m_mdr;
            e.err     = m_err;
            e.strobes = 0;
            sb.push_back(e);
            cur_lat   = 10;
            cur_rdata = 16'h4242;
            @(negedge clk);
            pc_addr  = 16'h0100;
            iord     = 1'b0;
            ir_write = 1'b1;
            mem_read = 1'b1;
            repeat (3) @(negedge clk);
            check("pre_reset_readM", {31'h0, readM}, 32'h1);
            reset    = 1'b1;
            mem_read = 1'b0;
            @(negedge clk);
            check("midrst_readM", {31'h0, readM}, 32'h0);
            check("midrst_ir", {16'h0, ir_out}, 32'h0);
            check("midrst_mdr", {16'h0, mdr_out}, 32'h0);
            check("midrst_done", {31'h0, mem_done}, 32'h0);
            check("midrst_err", {31'h0, mem_err}, 32'h0);
            sb.delete();
            m_ir  = 16'h0;
            m_mdr = 16'h0;
            m_err = 1'b0;
            @(negedge clk);
            reset = 1'b0;
            // Stray late handshakes from the memory model must be ignored.
            repeat (12) begin
                @(negedge clk);
                check("post_reset_quiet", {13'h0, readM, writeM, mem_done, ir_out}, 32'h0);
            end
        end
        do_txn(0, 1'b0, 1'b1, 16'h0010, 16'h0, 16'h0, 16'h6A05, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
